// File: rtl/npu_spi_pkg.sv
// npu_spi_pkg: shared FSM state type and default frame widths for the SPI link
package npu_spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    localparam int FRAME_W_DEF = 24;
    localparam int RSP_W_DEF = 8;
endpackage

// File: rtl/npu_sync_edge.sv
// npu_sync_edge: multi-flop synchroniser with registered rise/fall detection
module npu_sync_edge #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end
    assign level = sync[STAGES-1];
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/npu_spi_link.sv
// npu_spi_link: oversampled SPI slave taking FRAME_W-bit frames and returning an RSP_W-bit response
module npu_spi_link
    import npu_spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int RSP_W = RSP_W_DEF,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclk,
    input  logic               mosi,
    input  logic               cs_n,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_frame,
    output logic               rx_valid,
    input  logic               rx_ready,
    input  logic [RSP_W-1:0]   tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
);
    localparam int CW = $clog2(FRAME_W + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);
    localparam bit SAMPLE_LVL = CPOL ~^ CPHA;
    state_t state;
    logic [CW-1:0] cnt;
    logic [FRAME_W-2:0] rx_sh;
    logic [FRAME_W-1:0] rx_next;
    logic [RSP_W-1:0] tx_sh, tx_load;
    logic [SYNC_STAGES-1:0] mosi_sync, settle;
    logic armed, sclk_lvl, sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_fall, sample, drive;
    npu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    npu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    assign sample = (sclk_rise | sclk_fall) && sclk_lvl == SAMPLE_LVL;
    assign drive = (sclk_rise | sclk_fall) && sclk_lvl != SAMPLE_LVL;
    assign rx_next = {rx_sh, mosi_sync[SYNC_STAGES-1]};
    assign tx_load = tx_valid ? tx_data : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            rx_sh <= '0;
            tx_sh <= '0;
            mosi_sync <= '0;
            settle <= '0;
            armed <= 1'b0;
            miso <= 1'b0;
            rx_frame <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            armed <= armed | (settle[SYNC_STAGES-1] & cs_lvl);
            tx_ready <= 1'b0;
            frame_err <= 1'b0;
            if (err_clr) overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (cs_rise) begin
                state <= IDLE;
                miso <= 1'b0;
                frame_err <= state == SHIFT && cnt != '0;
            end else if (state == IDLE && cs_fall && armed) begin
                state <= SHIFT;
                cnt <= '0;
                tx_ready <= tx_valid;
                tx_sh <= CPHA ? tx_load : tx_load << 1;
                miso <= !CPHA && tx_load[RSP_W-1];
            end else if (state == SHIFT && sample) begin
                rx_sh <= rx_next[FRAME_W-2:0];
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state <= HOLD;
                    miso <= 1'b0;
                    if (!rx_valid || rx_ready) begin
                        rx_frame <= rx_next;
                        rx_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end else if (state == SHIFT && drive) begin
                miso <= tx_sh[RSP_W-1];
                tx_sh <= tx_sh << 1;
            end
        end
    end
endmodule

// File: tb/tb_npu_spi_link.sv
// tb_npu_spi_link: directed checks of the SPI slave link in all four SPI modes
module tb_npu_spi_link;
    localparam int H = 6;
    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0;
    logic rx_ready = 1'b1, tx_valid = 1'b0, err_clr = 1'b0;
    logic [3:0] csn = 4'hF;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] miso_v, rv_v, txr_v, fe_v, ov_v;
    logic [23:0] rxf0;
    logic [31:0] rxf_m [1:3];
    int total = 0, bad = 0;
    int rv_cnt [4] = '{default: 0};
    int tr_cnt [4] = '{default: 0};
    int fe_cnt [4] = '{default: 0};
    logic [3:0] rv_prev = 4'h0;
    always #5 clk = ~clk;
    npu_spi_link u_dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sck), .mosi(mosi), .cs_n(csn[0]), .miso(miso_v[0]),
        .rx_frame(rxf0), .rx_valid(rv_v[0]), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(txr_v[0]), .frame_err(fe_v[0]), .overrun(ov_v[0]),
        .err_clr(err_clr)
    );
    for (genvar g = 1; g < 4; g++) begin : g_mode
        localparam bit PL = g >= 2;
        localparam bit PH = (g % 2) == 1;
        npu_spi_link #(.FRAME_W(32), .CPOL(PL), .CPHA(PH)) u_dut (
            .clk(clk), .rst_n(rst_n), .sclk(sck ^ PL), .mosi(mosi), .cs_n(csn[g]), .miso(miso_v[g]),
            .rx_frame(rxf_m[g]), .rx_valid(rv_v[g]), .rx_ready(rx_ready), .tx_data(tx_data),
            .tx_valid(tx_valid), .tx_ready(txr_v[g]), .frame_err(fe_v[g]), .overrun(ov_v[g]),
            .err_clr(err_clr)
        );
    end
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            rv_cnt[m] += int'(rv_v[m] && !rv_prev[m]);
            tr_cnt[m] += int'(txr_v[m]);
            fe_cnt[m] += int'(fe_v[m]);
        end
        rv_prev = rv_v;
    end
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic bits(input int idx, input int n, input logic [63:0] data, output logic [31:0] mb);
        mb = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (idx % 2 == 0) begin
                mosi = data[i];
                wait_clk(H);
                mb = {mb[30:0], miso_v[idx]};
                sck = 1'b1;
                wait_clk(H);
                sck = 1'b0;
            end else begin
                wait_clk(H);
                sck = 1'b1;
                mosi = data[i];
                wait_clk(H);
                mb = {mb[30:0], miso_v[idx]};
                sck = 1'b0;
            end
        end
    endtask
    task automatic xfer(input int idx, input int n, input logic [63:0] data, output logic [31:0] mb);
        csn[idx] = 1'b0;
        wait_clk(H);
        bits(idx, n, data, mb);
        wait_clk(H);
        csn[idx] = 1'b1;
        wait_clk(2 * H);
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        wait_clk(3);
        total++; if (miso_v[0] !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso_v[0]); end
        total++; if (rxf0 !== 24'h0) begin bad++; $display("FAIL reset_rx_frame got=%h exp=000000", rxf0); end
        total++; if (rv_v[0] !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rv_v[0]); end
        total++; if (txr_v[0] !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b exp=0", txr_v[0]); end
        total++; if (fe_v[0] !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", fe_v[0]); end
        total++; if (ov_v[0] !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", ov_v[0]); end
        total++; if ({miso_v, rv_v, txr_v, fe_v, ov_v} !== 20'h0) begin bad++; $display("FAIL reset_all_modes got=%h exp=00000", {miso_v, rv_v, txr_v, fe_v, ov_v}); end
        rst_n = 1'b1;
        wait_clk(10);
    endtask
    task automatic test_mode0;
        logic [31:0] mb;
        int r0, t0, f0;
        r0 = rv_cnt[0]; t0 = tr_cnt[0]; f0 = fe_cnt[0];
        tx_data = 8'hC3; tx_valid = 1'b1; rx_ready = 1'b1;
        xfer(0, 24, 64'hA53C7E, mb);
        tx_valid = 1'b0;
        total++; if (rxf0 !== 24'hA53C7E) begin bad++; $display("FAIL mode0_rx_frame got=%h exp=a53c7e", rxf0); end
        total++; if (rv_cnt[0] - r0 != 1) begin bad++; $display("FAIL mode0_rx_valid_count got=%0d exp=1", rv_cnt[0] - r0); end
        total++; if (tr_cnt[0] - t0 != 1) begin bad++; $display("FAIL mode0_tx_ready_cycles got=%0d exp=1", tr_cnt[0] - t0); end
        total++; if (mb[23:0] !== 24'hC30000) begin bad++; $display("FAIL mode0_miso got=%h exp=c30000", mb[23:0]); end
        total++; if (fe_cnt[0] != f0) begin bad++; $display("FAIL mode0_frame_err got=%0d exp=0", fe_cnt[0] - f0); end
    endtask
    task automatic test_modes;
        logic [31:0] mb;
        int r0, t0;
        for (int m = 1; m < 4; m++) begin
            r0 = rv_cnt[m]; t0 = tr_cnt[m];
            tx_data = 8'h5A; tx_valid = 1'b1;
            xfer(m, 32, 64'hDEADBEEF, mb);
            tx_valid = 1'b0;
            total++; if (rxf_m[m] !== 32'hDEADBEEF) begin bad++; $display("FAIL mode%0d_rx_frame got=%h exp=deadbeef", m, rxf_m[m]); end
            total++; if (mb !== 32'h5A000000) begin bad++; $display("FAIL mode%0d_miso got=%h exp=5a000000", m, mb); end
            total++; if (rv_cnt[m] - r0 != 1) begin bad++; $display("FAIL mode%0d_rx_valid_count got=%0d exp=1", m, rv_cnt[m] - r0); end
            total++; if (tr_cnt[m] - t0 != 1) begin bad++; $display("FAIL mode%0d_tx_ready_cycles got=%0d exp=1", m, tr_cnt[m] - t0); end
            total++; if (ov_v[m] !== 1'b0 || fe_cnt[m] != 0) begin bad++; $display("FAIL mode%0d_errors got=%b/%0d exp=0/0", m, ov_v[m], fe_cnt[m]); end
        end
    endtask
    task automatic test_overrun;
        logic [31:0] mb;
        int r0, t0;
        r0 = rv_cnt[0]; t0 = tr_cnt[0];
        rx_ready = 1'b0; tx_valid = 1'b0;
        xfer(0, 24, 64'h000001, mb);
        total++; if (rv_v[0] !== 1'b1 || rxf0 !== 24'h000001) begin bad++; $display("FAIL ovr_first got=%b/%h exp=1/000001", rv_v[0], rxf0); end
        xfer(0, 24, 64'h000002, mb);
        total++; if (rxf0 !== 24'h000001) begin bad++; $display("FAIL ovr_frame_kept got=%h exp=000001", rxf0); end
        total++; if (ov_v[0] !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", ov_v[0]); end
        total++; if (rv_cnt[0] - r0 != 1) begin bad++; $display("FAIL ovr_rx_valid_count got=%0d exp=1", rv_cnt[0] - r0); end
        total++; if (mb !== 32'h0 || tr_cnt[0] != t0) begin bad++; $display("FAIL ovr_no_tx got=%h/%0d exp=0/0", mb, tr_cnt[0] - t0); end
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
        total++; if (ov_v[0] !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", ov_v[0]); end
        total++; if (rv_v[0] !== 1'b1) begin bad++; $display("FAIL ovr_valid_held got=%b exp=1", rv_v[0]); end
        rx_ready = 1'b1;
        wait_clk(2);
        total++; if (rv_v[0] !== 1'b0) begin bad++; $display("FAIL ovr_handshake got=%b exp=0", rv_v[0]); end
    endtask
    task automatic test_short;
        logic [31:0] mb;
        int r0, f0;
        r0 = rv_cnt[0]; f0 = fe_cnt[0];
        csn[0] = 1'b0;
        wait_clk(H);
        bits(0, 10, 64'h3FF, mb);
        wait_clk(H);
        csn[0] = 1'b1;
        wait_clk(2 * H);
        total++; if (fe_cnt[0] - f0 != 1) begin bad++; $display("FAIL short_frame_err got=%0d exp=1", fe_cnt[0] - f0); end
        total++; if (rv_cnt[0] != r0 || rv_v[0] !== 1'b0) begin bad++; $display("FAIL short_no_valid got=%0d/%b exp=0/0", rv_cnt[0] - r0, rv_v[0]); end
        total++; if (rxf0 !== 24'h000001) begin bad++; $display("FAIL short_frame_kept got=%h exp=000001", rxf0); end
        csn[0] = 1'b0;
        wait_clk(2 * H);
        csn[0] = 1'b1;
        wait_clk(2 * H);
        total++; if (fe_cnt[0] - f0 != 1) begin bad++; $display("FAIL empty_no_frame_err got=%0d exp=1", fe_cnt[0] - f0); end
        xfer(0, 24, 64'h5A5A5A, mb);
        total++; if (rxf0 !== 24'h5A5A5A || rv_cnt[0] - r0 != 1) begin bad++; $display("FAIL short_recover got=%h/%0d exp=5a5a5a/1", rxf0, rv_cnt[0] - r0); end
    endtask
    task automatic test_long;
        logic [31:0] mb;
        int r0, f0;
        r0 = rv_cnt[0]; f0 = fe_cnt[0];
        tx_valid = 1'b0;
        xfer(0, 26, 64'h3C3C3C3, mb);
        total++; if (rxf0 !== 24'hF0F0F0) begin bad++; $display("FAIL long_rx_frame got=%h exp=f0f0f0", rxf0); end
        total++; if (rv_cnt[0] - r0 != 1) begin bad++; $display("FAIL long_rx_valid_count got=%0d exp=1", rv_cnt[0] - r0); end
        total++; if (fe_cnt[0] != f0) begin bad++; $display("FAIL long_frame_err got=%0d exp=0", fe_cnt[0] - f0); end
        total++; if (mb !== 32'h0) begin bad++; $display("FAIL long_miso_zero got=%h exp=00000000", mb); end
    endtask
    task automatic test_reset_mid;
        logic [31:0] mb;
        int r0, f0;
        r0 = rv_cnt[0]; f0 = fe_cnt[0];
        csn[0] = 1'b0;
        wait_clk(H);
        bits(0, 12, 64'hABC, mb);
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        bits(0, 12, 64'hDEF, mb);
        wait_clk(H);
        csn[0] = 1'b1;
        wait_clk(2 * H);
        total++; if (rv_cnt[0] != r0 || rv_v[0] !== 1'b0) begin bad++; $display("FAIL rstmid_no_valid got=%0d/%b exp=0/0", rv_cnt[0] - r0, rv_v[0]); end
        total++; if (rxf0 !== 24'h0) begin bad++; $display("FAIL rstmid_rx_frame got=%h exp=000000", rxf0); end
        total++; if (fe_cnt[0] != f0) begin bad++; $display("FAIL rstmid_frame_err got=%0d exp=0", fe_cnt[0] - f0); end
        xfer(0, 24, 64'h123456, mb);
        total++; if (rxf0 !== 24'h123456 || rv_cnt[0] - r0 != 1) begin bad++; $display("FAIL rstmid_recover got=%h/%0d exp=123456/1", rxf0, rv_cnt[0] - r0); end
    endtask
    initial begin
        test_reset;
        test_mode0;
        test_modes;
        test_overrun;
        test_short;
        test_long;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
